// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   First-word-fall-through FIFO sitting behind the adder. Each entry holds the
//   sum plus the {sub, overflow, zero} tag. An exception tracker sits next to
//   the FIFO: a sticky overflow bit and a saturating overflow counter. Both
//   count only pushes that were actually accepted.
//
// Parameters
//   WIDTH      result data width
//   DEPTH      entry count; must be a power of two from 2 to 16, because the
//              pointers wrap by natural binary rollover
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     adder result presented on in_sum / flags
//   in_ready     an entry can be accepted (not full)
//   in_sum       adder sum
//   in_overflow  adder overflow flag
//   in_zero      adder zero flag
//   in_sub       operation tag, 1 = subtract
//   out_valid    head entry presented (not empty)
//   out_ready    consumer takes the head entry
//   out_data     head entry sum, 0 when empty
//   out_flags    head entry {sub, overflow, zero}, 0 when empty
//   clr_sticky   clears sticky_exc and ovf_count
//   sticky_exc   set by any accepted overflow push
//   ovf_count    saturating count of accepted overflow pushes
//   level        current occupancy
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_sum,
  input  logic                     in_overflow,
  input  logic                     in_zero,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [2:0]               out_flags,
  input  logic                     clr_sticky,
  output logic                     sticky_exc,
  output logic [7:0]               ovf_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = WIDTH + 3;

  // entry layout: {sub, overflow, zero, sum}
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Both handshakes depend only on level, so there is no path from out_ready
  // to in_ready; a full FIFO cannot push and pop in the same cycle.
  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is not reset; level and the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_sub, in_overflow, in_zero, in_sum};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  // Head is read straight from storage; a fresh word is only visible after
  // its push edge has bumped level.
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[WIDTH-1:0] : '0;
  assign out_flags = out_valid ? head[EW-1:WIDTH] : 3'b000;

  // An accepted overflow push wins over a clear in the same cycle, and
  // counts as the first event after that clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_exc <= 1'b0;
      ovf_count  <= 8'd0;
    end else if (push && in_overflow) begin
      sticky_exc <= 1'b1;
      if (clr_sticky) begin
        ovf_count <= 8'd1;
      end else if (ovf_count != 8'hFF) begin
        ovf_count <= ovf_count + 8'd1;
      end
    end else if (clr_sticky) begin
      sticky_exc <= 1'b0;
      ovf_count  <= 8'd0;
    end
  end

endmodule
